// File: rtl/mopshub_seq_pkg.sv
// Shared types and helpers for the MOPS-Hub test sequencer.
package mopshub_seq_pkg;

    localparam int unsigned PHASE_N  = 4;
    localparam int unsigned BUS_W    = 5;
    localparam int unsigned PH_IDX_W = 2;
    localparam int unsigned ERR_W    = PH_IDX_W + BUS_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_NEXT_BUS,
        S_GAP,
        S_NEXT_PHASE,
        S_DONE,
        S_ERR
    } seq_state_e;

    typedef enum logic [PH_IDX_W-1:0] {
        PH_TRIM = 2'd0,
        PH_RX   = 2'd1,
        PH_TX   = 2'd2,
        PH_CUST = 2'd3
    } phase_e;

    typedef struct packed {
        phase_e           phase;
        logic [BUS_W-1:0] bus;
    } err_info_t;

    // Index of the lowest set bit; callers guarantee mask is non-zero.
    function automatic phase_e lowest_phase(input logic [PHASE_N-1:0] mask);
        phase_e ph;
        ph = PH_TRIM;
        for (int i = int'(PHASE_N) - 1; i >= 0; i--) begin
            if (mask[i]) ph = phase_e'(PH_IDX_W'(i));
        end
        return ph;
    endfunction

    function automatic logic [PHASE_N-1:0] phase_onehot(input phase_e ph);
        return PHASE_N'(1) << ph;
    endfunction

endpackage

// File: rtl/mopshub_test_sequencer_if.sv
// Control/status bundle between the sign-on logic and the test sequencer.
interface mopshub_test_sequencer_if;
    import mopshub_seq_pkg::*;

    logic               start;
    logic               abort;
    logic [PHASE_N-1:0] phase_mask;
    logic [BUS_W-1:0]   n_buses;
    logic [PHASE_N-1:0] phase_done;
    logic [PHASE_N-1:0] phase_req;
    logic [BUS_W-1:0]   bus_sel;
    logic               endwait_pulse;
    logic               busy;
    logic               seq_done;
    logic               seq_err;
    logic [ERR_W-1:0]   err_info;

    modport master (
        output start, abort, phase_mask, n_buses, phase_done,
        input  phase_req, bus_sel, endwait_pulse, busy, seq_done, seq_err, err_info
    );

    modport slave (
        input  start, abort, phase_mask, n_buses, phase_done,
        output phase_req, bus_sel, endwait_pulse, busy, seq_done, seq_err, err_info
    );
endinterface

// File: rtl/mopshub_test_sequencer_timer.sv
// seq_timer: loadable down-counter, expiry flag is high while the count is zero.
module seq_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk_40_m,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expired_c
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign expired_c = (cnt_q == '0);
endmodule

// File: rtl/mopshub_test_sequencer.sv
// Sweeps enabled test phases over CAN buses 0..n_buses with an inter-phase gap.
// Define SEQ_TIMEOUT_EN to build the per-bus watchdog (WAIT -> ERR).
module mopshub_test_sequencer
    import mopshub_seq_pkg::*;
#(
    parameter int unsigned N_BUSES        = 32,
    parameter int unsigned GAP_CYCLES     = 120,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk_40_m,
    input  logic                    rst,
    mopshub_test_sequencer_if.slave seq_if
);
    localparam int unsigned TMR_LIM  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W    = (TMR_LIM > 0) ? $clog2(TMR_LIM + 1) : 1;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    localparam logic [BUS_W-1:0] LAST_BUS = BUS_W'(N_BUSES - 1);

    seq_state_e         state_q, state_d;
    logic [PHASE_N-1:0] mask_q, mask_d;
    logic [BUS_W-1:0]   last_q, last_d;
    logic [BUS_W-1:0]   bus_q, bus_d;
    phase_e             phase_q, phase_d;
    logic [PHASE_N-1:0] phase_req_q, phase_req_d;
    logic               endwait_q, endwait_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    phase_e             next_ph;
    logic               tmr_load, tmr_dec, tmr_exp;
    logic [TMR_W-1:0]   tmr_val;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TO_LOAD = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    logic      err_q, err_d;
    err_info_t err_info_q, err_info_d;
`endif

    assign next_ph = lowest_phase(mask_q);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        last_d   = last_q;
        bus_d    = bus_q;
        phase_d  = phase_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
`ifdef SEQ_TIMEOUT_EN
        err_info_d = err_info_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (seq_if.start) begin
                    state_d = S_LOAD;
                    mask_d  = seq_if.phase_mask;
                    last_d  = (seq_if.n_buses > LAST_BUS) ? LAST_BUS : seq_if.n_buses;
                    bus_d   = '0;
`ifdef SEQ_TIMEOUT_EN
                    err_info_d = '0;
`endif
                end
            end
            S_LOAD: state_d = S_NEXT_PHASE;
            // Remaining-phase mask is consumed lowest bit first.
            S_NEXT_PHASE: begin
                if (mask_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    phase_d = next_ph;
                    mask_d  = mask_q & ~phase_onehot(next_ph);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(TO_LOAD);
`endif
            end
            // Completion in the expiry cycle still counts as success.
            S_WAIT: begin
                if (seq_if.phase_done[phase_q]) state_d = S_NEXT_BUS;
`ifdef SEQ_TIMEOUT_EN
                else if (tmr_exp) begin
                    state_d          = S_ERR;
                    err_info_d.phase = phase_q;
                    err_info_d.bus   = bus_q;
                end else tmr_dec = 1'b1;
`endif
            end
            S_NEXT_BUS: begin
                if (bus_q == last_q) begin
                    bus_d    = '0;
                    state_d  = S_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_LOAD);
                end else begin
                    bus_d   = bus_q + BUS_W'(1);
                    state_d = S_REQ;
                end
            end
            S_GAP: begin
                if (tmr_exp) state_d = S_NEXT_PHASE;
                else         tmr_dec = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (seq_if.abort) begin
            state_d  = S_IDLE;
            mask_d   = '0;
            last_d   = '0;
            bus_d    = '0;
            phase_d  = PH_TRIM;
            tmr_load = 1'b1;
            tmr_val  = '0;
            tmr_dec  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
            err_info_d = '0;
`endif
        end

        // Outputs are registered from the next state.
        phase_req_d = ((state_d == S_REQ) || (state_d == S_WAIT)) ? phase_onehot(phase_d) : '0;
        endwait_d   = (state_d == S_GAP) && (state_q != S_GAP);
        busy_d      = !(state_d inside {S_IDLE, S_DONE, S_ERR});
        done_d      = (state_d == S_DONE);
`ifdef SEQ_TIMEOUT_EN
        err_d       = (state_d == S_ERR);
`endif
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            last_q      <= '0;
            bus_q       <= '0;
            phase_q     <= PH_TRIM;
            phase_req_q <= '0;
            endwait_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            last_q      <= last_d;
            bus_q       <= bus_d;
            phase_q     <= phase_d;
            phase_req_q <= phase_req_d;
            endwait_q   <= endwait_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    seq_timer #(.W(TMR_W)) u_timer (
        .clk_40_m   (clk_40_m),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .expired_c  (tmr_exp)
    );

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            err_q      <= 1'b0;
            err_info_q <= '0;
        end else begin
            err_q      <= err_d;
            err_info_q <= err_info_d;
        end
    end

    assign seq_if.seq_err  = err_q;
    assign seq_if.err_info = err_info_q;
`else
    assign seq_if.seq_err  = 1'b0;
    assign seq_if.err_info = '0;
`endif

    assign seq_if.phase_req     = phase_req_q;
    assign seq_if.bus_sel       = bus_q;
    assign seq_if.endwait_pulse = endwait_q;
    assign seq_if.busy          = busy_q;
    assign seq_if.seq_done      = done_q;
endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Bench for mopshub_test_sequencer: expected per-cycle trace built from the sweep rules.
module tb_mopshub_test_sequencer;
    localparam int NB  = 8;
    localparam int GAP = 120;
    localparam int TO  = 16;

    typedef struct packed {
        logic [3:0] req;
        logic [4:0] bus;
        logic       ew;
        logic       busy;
        logic       done;
        logic       err;
        logic [6:0] info;
        logic [3:0] pd;
    } step_t;

    logic clk_40_m = 1'b0;
    logic rst;
    always #12 clk_40_m = ~clk_40_m;

    mopshub_test_sequencer_if sif ();

    mopshub_test_sequencer #(
        .N_BUSES        (NB),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_40_m (clk_40_m),
        .rst      (rst),
        .seq_if   (sif)
    );

    int    total = 0;
    int    bad   = 0;
    step_t q[$];
    int    ew_cnt, max_bus, done_cyc;
    int    req_seen[$];
    logic [3:0] prev_req;
    int    exp_req[4];
    step_t zero_s;

    function automatic step_t mk(input logic [3:0] req, input int bus, input logic ew,
                                 input logic busy, input logic done, input logic err,
                                 input logic [6:0] info, input logic [3:0] pd);
        step_t s;
        s.req = req; s.bus = 5'(bus); s.ew = ew; s.busy = busy;
        s.done = done; s.err = err; s.info = info; s.pd = pd;
        return s;
    endfunction

    // Expected outputs per cycle after start; pd is the phase_done stimulus for that cycle.
    task automatic build(input logic [3:0] mask, input int nb, input int d,
                         input logic noise, input int stall_bus);
        int last, gap_len;
        logic [3:0] oh, pd;
        q.delete();
        last    = (nb > NB - 1) ? NB - 1 : nb;
        gap_len = (GAP > 0) ? GAP : 1;
        q.push_back(mk(4'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 4'b0));
        for (int p = 0; p < 4; p++) begin
            if (mask[p]) begin
                oh = 4'b0001 << p;
                q.push_back(mk(4'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 4'b0));
                for (int b = 0; b <= last; b++) begin
                    if (b == stall_bus) begin
                        for (int k = 0; k <= TO; k++)
                            q.push_back(mk(oh, b, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 4'b0));
                        q.push_back(mk(4'b0, b, 1'b0, 1'b0, 1'b0, 1'b1, {2'(p), 5'(b)}, 4'b0));
                        return;
                    end
                    for (int k = 0; k <= d; k++) begin
                        pd = (k == d) ? oh : ((noise && k == 2) ? ~oh : 4'b0);
                        q.push_back(mk(oh, b, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, pd));
                    end
                    q.push_back(mk(4'b0, b, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 4'b0));
                end
                for (int g = 0; g < gap_len; g++)
                    q.push_back(mk(4'b0, 0, g == 0, 1'b1, 1'b0, 1'b0, 7'd0, 4'b0));
            end
        end
        q.push_back(mk(4'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 4'b0));
        q.push_back(mk(4'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0, 4'b0));
    endtask

    task automatic check(input string tag, input int cyc, input step_t e);
        logic [19:0] act, exp;
        act = {sif.phase_req, sif.bus_sel, sif.endwait_pulse, sif.busy,
               sif.seq_done, sif.seq_err, sif.err_info};
        exp = {e.req, e.bus, e.ew, e.busy, e.done, e.err, e.info};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%05h want=%05h", tag, cyc, act, exp);
        end
        if (sif.endwait_pulse === 1'b1) ew_cnt++;
        if (int'(sif.bus_sel) > max_bus) max_bus = int'(sif.bus_sel);
        if (sif.seq_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (sif.phase_req != 4'b0 && sif.phase_req != prev_req) req_seen.push_back(int'(sif.phase_req));
        prev_req = sif.phase_req;
    endtask

    task automatic pin(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] mask, input logic [4:0] nb,
                       input int abort_at, input logic use_rst, input logic start_on_abort);
        ew_cnt = 0; max_bus = 0; done_cyc = -1; prev_req = 4'b0;
        req_seen.delete();
        sif.start = 1'b1; sif.phase_mask = mask; sif.n_buses = nb;
        @(posedge clk_40_m); #1;
        sif.start = 1'b0; sif.phase_mask = ~mask; sif.n_buses = nb ^ 5'h15;
        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_at) begin
                check(tag, i + 1, q[i]);
                sif.phase_done = 4'b0;
                if (use_rst) rst = 1'b0;
                else         sif.abort = 1'b1;
                sif.start = start_on_abort;
                @(posedge clk_40_m); #1;
                check({tag, "_zero"}, i + 2, zero_s);
                rst = 1'b1; sif.abort = 1'b0; sif.start = 1'b0;
                return;
            end
            check(tag, i + 1, q[i]);
            sif.phase_done = q[i].pd;
            @(posedge clk_40_m); #1;
        end
        sif.phase_done = 4'b0;
        check({tag, "_hold"}, q.size() + 1, q[q.size() - 1]);
    endtask

    initial begin
        exp_req[0] = 1; exp_req[1] = 2; exp_req[2] = 4; exp_req[3] = 8;
        zero_s = mk(4'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 4'b0);
        rst = 1'b0;
        sif.start = 1'b0; sif.abort = 1'b0; sif.phase_mask = 4'b0;
        sif.n_buses = 5'd0; sif.phase_done = 4'b0;
        repeat (3) @(posedge clk_40_m);
        #1;
        check("reset", 0, zero_s);
        rst = 1'b1;
        @(posedge clk_40_m); #1;
        check("idle", 0, zero_s);

        // RX only, buses 0..2, done 5 cycles after each request, stray done bits
        build(4'b0010, 2, 5, 1'b1, -1);
        pin("rx_model_len", q.size(), 145);
        run("rx_sweep", 4'b0010, 5'd2, -1, 1'b0, 1'b0);
        pin("rx_done_cycle", done_cyc, 145);
        pin("rx_endwait", ew_cnt, 1);
        pin("rx_max_bus", max_bus, 2);

        // All phases, single bus
        build(4'b1111, 0, 3, 1'b0, -1);
        run("all_phases", 4'b1111, 5'd0, -1, 1'b0, 1'b0);
        pin("all_endwait", ew_cnt, 4);
        pin("all_req_count", req_seen.size(), 4);
        for (int i = 0; i < req_seen.size() && i < 4; i++) pin("all_req_order", req_seen[i], exp_req[i]);
        pin("all_done_cycle", done_cyc, 507);

        // Empty mask
        build(4'b0000, 3, 1, 1'b0, -1);
        run("empty", 4'b0000, 5'd3, -1, 1'b0, 1'b0);
        pin("empty_done_cycle", done_cyc, 3);
        pin("empty_req_count", req_seen.size(), 0);

        // Abort (with a competing start) in WAIT at bus 7, then a clean re-run
        build(4'b0100, 7, 4, 1'b0, -1);
        run("abort", 4'b0100, 5'd7, 46, 1'b0, 1'b1);
        build(4'b0100, 1, 2, 1'b0, -1);
        run("after_abort", 4'b0100, 5'd1, -1, 1'b0, 1'b0);
        pin("after_abort_max_bus", max_bus, 1);

        // Reset in WAIT at bus 7, then a clean re-run
        build(4'b0100, 7, 4, 1'b0, -1);
        run("rst_mid", 4'b0100, 5'd7, 46, 1'b1, 1'b0);
        build(4'b0100, 1, 2, 1'b0, -1);
        run("after_rst", 4'b0100, 5'd1, -1, 1'b0, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        build(4'b0100, 5, 2, 1'b0, 3);
        run("timeout", 4'b0100, 5'd5, -1, 1'b0, 1'b0);
        pin("timeout_err_info", int'(sif.err_info), 'h43);
`endif

        // n_buses clamp; done lands exactly on the watchdog limit
        build(4'b0001, 31, 16, 1'b0, -1);
        run("clamp", 4'b0001, 5'd31, -1, 1'b0, 1'b0);
        pin("clamp_max_bus", max_bus, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
